wb_burst_responder: RTL
=======================

// Module: wb_burst_responder
// PURPOSE
//  Wishbone slave-side responder: the far end of a wb slave port. Accepts single/burst
//  requests (bl/bry extension) and answers with dat/ack/lack/err. Backed by a 1-cycle-latency
//  32-bit synchronous SRAM macro. Used behind any interconnect slave port needing burst memory.
// PARAMETERS
//  AW  8  word-address width; memory depth = 2**AW words (byte span 4*2**AW)
// PORTS
//  clk_i        in   1   clock
//  rst_i        in   1   reset: asynchronous, active-high
//  wbs_dat_i    in   32  write data, current beat
//  wbs_adr_i    in   32  byte address of first beat, [1:0] ignored
//  wbs_sel_i    in   4   byte enables, all beats
//  wbs_bl_i     in   10  burst length in beats; 0 treated as 1
//  wbs_bry_i    in   1   master ready for next beat (wr: dat valid; rd: can take data)
//  wbs_we_i     in   1   1=write 0=read
//  wbs_cyc_i    in   1   bus cycle
//  wbs_stb_i    in   1   request strobe
//  wbs_dat_o    out  32  read data, valid with ack_o on reads
//  wbs_ack_o    out  1   beat acknowledge, 1-cycle pulse
//  wbs_lack_o   out  1   last-beat acknowledge, coincident with final ack_o
//  wbs_err_o    out  1   error, coincident with ack_o/lack_o
//  mem_cs_o     out  1   SRAM select
//  mem_we_o     out  1   SRAM write
//  mem_addr_o   out  AW  SRAM word address
//  mem_wmask_o  out  4   SRAM byte mask (=sel)
//  mem_wdata_o  out  32  SRAM write data
//  mem_rdata_i  in   32  SRAM read data, valid cycle after cs&!we
// BEHAVIOUR
//  Reset: all wbs_*_o and mem_*_o = 0, state IDLE, beat counter 0, address reg 0.
//  Outputs wbs_ack/lack/err/dat are registered; mem_* outputs are combinational from state/regs.
//  FSM: IDLE, WR, RD_REQ, RD_ACK, ERR, DONE.
//  IDLE: on cyc&stb: latch word addr = adr[AW+1:2], remaining = (bl==0)?1:bl, sel, we.
//    adr[31:AW+2]!=0 -> ERR; else we ? WR : RD_REQ.
//  WR: cycle with stb&bry&!ack_o: mem_cs=mem_we=1, addr=reg, wdata=dat_i, wmask=sel;
//    next cycle ack_o=1 (lack_o=1 if remaining==1); addr+1, remaining-1.
//    Max rate 1 beat / 2 cycles. bry=0 -> stall, no memory access, no ack.
//  RD_REQ: mem_cs=1, mem_we=0, addr=reg -> RD_ACK next cycle; data captured into holding reg.
//  RD_ACK: if bry: ack_o=1 next cycle, dat_o=held data, lack_o if last; addr+1, remaining-1;
//    go RD_REQ (more beats) or DONE. If !bry: hold data, no re-read, stay.
//  ERR: one pulse ack_o=lack_o=err_o=1, dat_o=0, no memory access, then DONE.
//  DONE: wait until stb=0 or cyc=0, then IDLE (prevents re-trigger on lingering stb).
//  Address increments modulo 2**AW (wraps, not an error, within a burst).
//  sel applies unchanged to every beat; reads ignore sel (full word returned).
//  Abort: cyc=0 in WR/RD_REQ/RD_ACK -> IDLE next cycle; no ack for pending beat;
//    a write already issued to memory stays written.
//  Reset mid-burst: immediate return to reset state; pending ack/lack dropped.
//  ack_o never asserted in consecutive cycles; lack_o only ever with ack_o.
//  Single access (bl=1): write ack 2 cycles after stb&bry; read ack 3 cycles after stb.
// TESTING
//  1 single wr adr=0x10 dat=0xA5A5_1234 sel=F, then rd adr=0x10 -> ack+lack, dat_o=0xA5A5_1234
//  2 wr burst adr=0x0 bl=4 dat 1..4, rd burst bl=4 -> 4 acks, lack on 4th only, data 1,2,3,4
//  3 rd burst bl=3 with bry low 5 cycles before beat 2 -> no extra mem_cs, beat 2 data intact
//  4 adr=0x400 (AW=8) -> single ack+lack+err, dat_o=0, mem_cs never asserted
//  5 wr burst adr=4*255 bl=2 -> words 255 and 0 written (wrap); sel=0x2 preserves other bytes
//  6 cyc drop after beat 1 of bl=4 read -> IDLE, no further ack; rst_i mid-burst -> outputs 0

Source files
------------

// File: rtl/wb_burst_if.sv
// Wishbone slave-port bundle with the bl/bry burst extension.
// Signal names keep the slave-side view: *_i flows master->slave, *_o flows slave->master.
interface wb_burst_if;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic [3:0]  wbs_sel_i;
  logic [9:0]  wbs_bl_i;
  logic        wbs_bry_i;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o;
  logic        wbs_lack_o;
  logic        wbs_err_o;

  modport master (
    output wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bl_i, wbs_bry_i,
           wbs_we_i, wbs_cyc_i, wbs_stb_i,
    input  wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o
  );

  modport slave (
    input  wbs_dat_i, wbs_adr_i, wbs_sel_i, wbs_bl_i, wbs_bry_i,
           wbs_we_i, wbs_cyc_i, wbs_stb_i,
    output wbs_dat_o, wbs_ack_o, wbs_lack_o, wbs_err_o
  );
endinterface

// File: rtl/wb_burst_responder.sv
// Wishbone burst responder in front of a 1-cycle-latency 32-bit SRAM.
// Handshake: a write beat is taken in WR when stb & bry & !ack_o; a read beat is
// delivered from RD_ACK when bry is high. ack_o/lack_o/err_o/dat_o are registered
// one-cycle pulses; mem_* are combinational from state and the latched burst regs.
module wb_burst_responder #(
  parameter int AW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wb_burst_if.slave     wbs,
  output logic          mem_cs_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [3:0]    mem_wmask_o,
  output logic [31:0]   mem_wdata_o,
  input  logic [31:0]   mem_rdata_i,
  output logic [2:0]    o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR     = 3'd1,
    S_RD_REQ = 3'd2,
    S_RD_ACK = 3'd3,
    S_ERR    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [9:0]    r_remain;
  logic [3:0]    r_sel;
  logic [31:0]   r_hold;
  logic          r_fresh;
  logic          r_ack;
  logic          r_lack;
  logic          r_err;
  logic [31:0]   r_dat;

  logic          w_start;
  logic          w_wr_beat;
  logic          w_rd_beat;
  logic          w_rd_issue;
  logic          w_last;
  logic          w_adr_bad;
  logic [31:0]   w_rd_word;
  logic          w_unused_adr;

  // Byte-offset bits carry no meaning for word accesses.
  assign w_unused_adr = &{1'b0, wbs.wbs_adr_i[1:0]};

  assign w_adr_bad = |wbs.wbs_adr_i[31:AW+2];
  assign w_last    = (r_remain == 10'd1);
  // On the first RD_ACK cycle the SRAM output is live; afterwards only the held copy is.
  assign w_rd_word = r_fresh ? mem_rdata_i : r_hold;

  // Next-state and per-cycle beat decisions.
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_wr_beat  = 1'b0;
    w_rd_beat  = 1'b0;
    w_rd_issue = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wbs.wbs_cyc_i && wbs.wbs_stb_i) begin
          w_start = 1'b1;
          if (w_adr_bad)          w_next = S_ERR;
          else if (wbs.wbs_we_i)  w_next = S_WR;
          else                    w_next = S_RD_REQ;
        end
      end
      S_WR: begin
        if (!wbs.wbs_cyc_i) begin
          w_next = S_IDLE;
        end else if (wbs.wbs_stb_i && wbs.wbs_bry_i && !r_ack) begin
          w_wr_beat = 1'b1;
          if (w_last) w_next = S_DONE;
        end
      end
      S_RD_REQ: begin
        if (!wbs.wbs_cyc_i) begin
          w_next = S_IDLE;
        end else begin
          w_rd_issue = 1'b1;
          w_next     = S_RD_ACK;
        end
      end
      S_RD_ACK: begin
        if (!wbs.wbs_cyc_i) begin
          w_next = S_IDLE;
        end else if (wbs.wbs_bry_i) begin
          w_rd_beat = 1'b1;
          w_next    = w_last ? S_DONE : S_RD_REQ;
        end
      end
      S_ERR:  w_next = S_DONE;
      S_DONE: begin
        if (!wbs.wbs_stb_i || !wbs.wbs_cyc_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Burst bookkeeping, read holding register and registered bus responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_sel    <= '0;
      r_hold   <= '0;
      r_fresh  <= 1'b0;
      r_ack    <= 1'b0;
      r_lack   <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= '0;
    end else begin
      r_ack   <= 1'b0;
      r_lack  <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      r_fresh <= w_rd_issue;
      if (r_fresh) r_hold <= mem_rdata_i;
      if (w_start) begin
        r_addr   <= wbs.wbs_adr_i[AW+1:2];
        r_remain <= (wbs.wbs_bl_i == 10'd0) ? 10'd1 : wbs.wbs_bl_i;
        r_sel    <= wbs.wbs_sel_i;
      end
      if (w_wr_beat || w_rd_beat) begin
        r_ack    <= 1'b1;
        r_lack   <= w_last;
        r_addr   <= r_addr + 1'b1;
        r_remain <= r_remain - 10'd1;
      end
      if (w_rd_beat) r_dat <= w_rd_word;
      if (r_state == S_ERR) begin
        r_ack  <= 1'b1;
        r_lack <= 1'b1;
        r_err  <= 1'b1;
      end
    end
  end

  assign mem_cs_o    = w_wr_beat | w_rd_issue;
  assign mem_we_o    = w_wr_beat;
  assign mem_addr_o  = r_addr;
  assign mem_wmask_o = r_sel;
  assign mem_wdata_o = w_wr_beat ? wbs.wbs_dat_i : 32'd0;

  assign wbs.wbs_ack_o  = r_ack;
  assign wbs.wbs_lack_o = r_lack;
  assign wbs.wbs_err_o  = r_err;
  assign wbs.wbs_dat_o  = r_dat;

  assign o_dbg_state = r_state;

endmodule
